// File: rtl/theta_page_controller_pkg.sv
// Shared types for the theta page controller: FSM state encoding, registered
// control-strobe bundle, counter width helper and the state-to-strobe decode.
package theta_page_controller_pkg;

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_INIT  = 4'd1,
        S_REQ   = 4'd2,
        S_LOAD  = 4'd3,
        S_PAR   = 4'd4,
        S_XOR   = 4'd5,
        S_WR    = 4'd6,
        S_LDF   = 4'd7,
        S_PAR1  = 4'd8,
        S_XOR1  = 4'd9,
        S_WR1   = 4'd10,
        S_OINIT = 4'd11,
        S_OUT   = 4'd12,
        S_DONE  = 4'd13
    } state_e;

    typedef struct packed {
        logic ready;
        logic in_ready;
        logic out_valid;
        logic done;
        logic mem_rd;
        logic mem_wr;
        logic adr_src;
        logic reg_src;
        logic reg_ld;
        logic reg_clr;
        logic reg_shr;
        logic col_shr;
        logic col_clr;
        logic xor_src;
        logic par_ld;
        logic par_clr;
    } ctrl_t;

    // Width of a counter holding 0..n-1 (PAGE_W, ROW_W and LANE_W all derive from this).
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic ctrl_t decode(input state_e s);
        ctrl_t c;
        c = '0;
        case (s)
            S_IDLE:  c.ready = 1'b1;
            S_REQ:   begin c.in_ready = 1'b1; c.reg_clr = 1'b1; c.col_clr = 1'b1; c.par_clr = 1'b1; end
            S_LOAD:  c.reg_ld = 1'b1;
            S_PAR,
            S_PAR1:  c.col_shr = 1'b1;
            S_XOR:   c.reg_shr = 1'b1;
            S_XOR1:  begin c.reg_shr = 1'b1; c.xor_src = 1'b1; end
            S_WR:    begin c.mem_wr = 1'b1; c.par_ld = 1'b1; end
            S_LDF:   begin
                c.adr_src = 1'b1; c.reg_src = 1'b1; c.mem_rd = 1'b1;
                c.reg_ld  = 1'b1; c.col_clr = 1'b1;
            end
            S_WR1:   begin c.mem_wr = 1'b1; c.adr_src = 1'b1; end
            S_OUT:   begin c.mem_rd = 1'b1; c.out_valid = 1'b1; end
            S_DONE:  c.done = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/theta_page_controller_if.sv
// Stream handshake plus page-memory / shift-register control bus of the theta
// page controller; master = environment side, slave = controller side.
interface theta_page_controller_if
    import theta_page_controller_pkg::*;
#(
    parameter int PAGES = 64
);
    localparam int PAGE_W = cnt_w(PAGES);

    logic              start;
    logic              bypass;
    logic              ready;
    logic              in_valid;
    logic              in_ready;
    logic              out_valid;
    logic              out_ready;
    logic              done;
    logic [PAGE_W-1:0] page_idx;
    logic              mem_rd;
    logic              mem_wr;
    logic              adr_src;
    logic              reg_src;
    logic              reg_ld;
    logic              reg_clr;
    logic              reg_shr;
    logic              col_shr;
    logic              col_clr;
    logic              xor_src;
    logic              par_ld;
    logic              par_clr;

    modport master (
        output start, bypass, in_valid, out_ready,
        input  ready, in_ready, out_valid, done, page_idx,
        input  mem_rd, mem_wr, adr_src, reg_src, reg_ld, reg_clr, reg_shr,
        input  col_shr, col_clr, xor_src, par_ld, par_clr
    );

    modport slave (
        input  start, bypass, in_valid, out_ready,
        output ready, in_ready, out_valid, done, page_idx,
        output mem_rd, mem_wr, adr_src, reg_src, reg_ld, reg_clr, reg_shr,
        output col_shr, col_clr, xor_src, par_ld, par_clr
    );

endinterface

// File: rtl/theta_page_controller_mod_counter.sv
// Modulo-MOD up counter with synchronous clear; o_co flags the wrapping increment.
module theta_page_controller_mod_counter
    import theta_page_controller_pkg::*;
#(
    parameter int MOD = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_clr,
    input  logic                  i_en,
    output logic [cnt_w(MOD)-1:0] o_count,
    output logic                  o_co
);
    localparam int W = cnt_w(MOD);

    logic [W-1:0] r_count;
    logic         w_last;

    assign w_last = (r_count == W'(MOD - 1));

    // NOTE: clear wins over enable, so a clearing state never leaks a stray count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= w_last ? '0 : r_count + W'(1);
        end
    end

    assign o_count = r_count;
    assign o_co    = i_en && w_last;

endmodule

// File: rtl/theta_page_controller.sv
// Page-wise column-parity/XOR sequencer: loads PAGES pages, runs parity and XOR
// phases per page, wraps up with page 0, then streams the block out.
module theta_page_controller
    import theta_page_controller_pkg::*;
#(
    parameter int PAGES = 64,
    parameter int ROWS  = 5,
    parameter int COLS  = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    theta_page_controller_if.slave  bus
);
    localparam int PAGE_W = cnt_w(PAGES);
    localparam int ROW_W  = cnt_w(ROWS);
    localparam int LANE_W = cnt_w(ROWS * COLS);

    state_e            r_state;
    state_e            w_next;
    ctrl_t             r_ctrl;
    logic              r_bypass;

    logic [PAGE_W-1:0] w_page_cnt;
    logic [ROW_W-1:0]  w_col_cnt;
    logic [LANE_W-1:0] w_lane_cnt;
    logic              w_page_co;
    logic              w_col_co;
    logic              w_lane_co;
    logic              w_unused_cnts;

    // Phase lengths come from the carries; the raw column/lane counts have no consumer here.
    assign w_unused_cnts = ^{w_col_cnt, w_lane_cnt};

    theta_page_controller_mod_counter #(.MOD(PAGES)) u_page_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clr   (r_state == S_INIT || r_state == S_OINIT),
        .i_en    (r_state == S_WR || (r_state == S_OUT && bus.out_ready)),
        .o_count (w_page_cnt),
        .o_co    (w_page_co)
    );

    theta_page_controller_mod_counter #(.MOD(ROWS)) u_col_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clr   (r_state == S_REQ || r_state == S_LDF),
        .i_en    (r_state == S_PAR || r_state == S_PAR1),
        .o_count (w_col_cnt),
        .o_co    (w_col_co)
    );

    theta_page_controller_mod_counter #(.MOD(ROWS * COLS)) u_lane_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clr   (r_state == S_REQ || r_state == S_LDF),
        .i_en    (r_state == S_XOR || r_state == S_XOR1),
        .o_count (w_lane_cnt),
        .o_co    (w_lane_co)
    );

    // NOTE: every variable driven here gets a default first, so no latch is inferred.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.start) w_next = S_INIT;
            S_INIT:  w_next = S_REQ;
            S_REQ:   if (bus.in_valid) w_next = S_LOAD;
            S_LOAD:  w_next = r_bypass ? S_WR : S_PAR;
            S_PAR:   if (w_col_co) w_next = S_XOR;
            S_XOR:   if (w_lane_co) w_next = S_WR;
            S_WR:    if (w_page_co) w_next = r_bypass ? S_OINIT : S_LDF;
                     else           w_next = S_REQ;
            S_LDF:   w_next = S_PAR1;
            S_PAR1:  if (w_col_co) w_next = S_XOR1;
            S_XOR1:  if (w_lane_co) w_next = S_WR1;
            S_WR1:   w_next = S_OINIT;
            S_OINIT: w_next = S_OUT;
            S_OUT:   if (w_page_co) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // NOTE: strobes are decoded from the next state and registered, so they change
    // exactly with the state register and never glitch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_ctrl   <= decode(S_IDLE);
            r_bypass <= 1'b0;
        end else begin
            r_state <= w_next;
            r_ctrl  <= decode(w_next);
            if (r_state == S_IDLE && bus.start) begin
                r_bypass <= bus.bypass;
            end
        end
    end

    assign bus.ready     = r_ctrl.ready;
    assign bus.in_ready  = r_ctrl.in_ready;
    assign bus.out_valid = r_ctrl.out_valid;
    assign bus.done      = r_ctrl.done;
    assign bus.mem_rd    = r_ctrl.mem_rd;
    assign bus.mem_wr    = r_ctrl.mem_wr;
    assign bus.adr_src   = r_ctrl.adr_src;
    assign bus.reg_src   = r_ctrl.reg_src;
    assign bus.reg_ld    = r_ctrl.reg_ld;
    assign bus.reg_clr   = r_ctrl.reg_clr;
    assign bus.reg_shr   = r_ctrl.reg_shr;
    assign bus.col_shr   = r_ctrl.col_shr;
    assign bus.col_clr   = r_ctrl.col_clr;
    assign bus.xor_src   = r_ctrl.xor_src;
    assign bus.par_ld    = r_ctrl.par_ld;
    assign bus.par_clr   = r_ctrl.par_clr;
    assign bus.page_idx  = r_ctrl.adr_src ? '0 : w_page_cnt;

endmodule

// File: tb/tb_theta_page_controller.sv
// Self-checking bench for theta_page_controller: a PAGES=4 and a PAGES=3 instance,
// randomized stalls checked against a cycle-count and event-count reference model.
module tb_theta_page_controller;

    localparam int ROWS = 5;
    localparam int COLS = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    theta_page_controller_if #(.PAGES(4)) bus4 ();
    theta_page_controller_if #(.PAGES(3)) bus3 ();

    theta_page_controller #(.PAGES(4), .ROWS(ROWS), .COLS(COLS)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4.slave)
    );

    theta_page_controller #(.PAGES(3), .ROWS(ROWS), .COLS(COLS)) dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus3.slave)
    );

    // Stimulus goes to the selected instance only; the other one sits idle.
    logic sel3;
    logic d_start, d_bypass, d_in_valid, d_out_ready;

    assign bus4.start     = !sel3 && d_start;
    assign bus4.bypass    = !sel3 && d_bypass;
    assign bus4.in_valid  = !sel3 && d_in_valid;
    assign bus4.out_ready = !sel3 && d_out_ready;
    assign bus3.start     = sel3 && d_start;
    assign bus3.bypass    = sel3 && d_bypass;
    assign bus3.in_valid  = sel3 && d_in_valid;
    assign bus3.out_ready = sel3 && d_out_ready;

    logic        v_ready, v_in_ready, v_out_valid, v_done, v_mem_rd, v_mem_wr;
    logic        v_adr_src, v_reg_shr, v_col_shr, v_xor_src;
    logic [31:0] v_page;
    logic [14:0] v_str;

    assign v_ready     = sel3 ? bus3.ready     : bus4.ready;
    assign v_in_ready  = sel3 ? bus3.in_ready  : bus4.in_ready;
    assign v_out_valid = sel3 ? bus3.out_valid : bus4.out_valid;
    assign v_done      = sel3 ? bus3.done      : bus4.done;
    assign v_mem_rd    = sel3 ? bus3.mem_rd    : bus4.mem_rd;
    assign v_mem_wr    = sel3 ? bus3.mem_wr    : bus4.mem_wr;
    assign v_adr_src   = sel3 ? bus3.adr_src   : bus4.adr_src;
    assign v_reg_shr   = sel3 ? bus3.reg_shr   : bus4.reg_shr;
    assign v_col_shr   = sel3 ? bus3.col_shr   : bus4.col_shr;
    assign v_xor_src   = sel3 ? bus3.xor_src   : bus4.xor_src;
    assign v_page      = sel3 ? 32'(bus3.page_idx) : 32'(bus4.page_idx);
    assign v_str = sel3 ?
        {bus3.in_ready, bus3.out_valid, bus3.done, bus3.mem_rd, bus3.mem_wr, bus3.adr_src,
         bus3.reg_src, bus3.reg_ld, bus3.reg_clr, bus3.reg_shr, bus3.col_shr, bus3.col_clr,
         bus3.xor_src, bus3.par_ld, bus3.par_clr} :
        {bus4.in_ready, bus4.out_valid, bus4.done, bus4.mem_rd, bus4.mem_wr, bus4.adr_src,
         bus4.reg_src, bus4.reg_ld, bus4.reg_clr, bus4.reg_shr, bus4.col_shr, bus4.col_clr,
         bus4.xor_src, bus4.par_ld, bus4.par_clr};

    // Per-page stall lengths: cycles in_valid is withheld in REQ / out_ready withheld in OUT.
    int in_dly  [0:3];
    int out_dly [0:3];

    task automatic clear_dly();
        for (int i = 0; i < 4; i++) begin
            in_dly[i]  = 0;
            out_dly[i] = 0;
        end
    endtask

    // One full block; expectations come from the cycle formula plus the chosen stalls
    // and from event counts implied by the page/row/column structure.
    task automatic run_block(input string name, input bit byp, input bit poke);
        int p, exp_cyc, exp_out, cyc, done_cyc, done_cnt, post;
        int in_page, in_wait, out_page, out_wait, wr_idx;
        int n_col, n_shr, n_xor, n_wr, n_out;
        bit last_wr_adr;
        p = sel3 ? 3 : 4;
        exp_cyc = byp ? 4 * p + 3 : p * (3 + ROWS + ROWS * COLS) + ROWS + ROWS * COLS + p + 5;
        exp_out = p;
        for (int i = 0; i < p; i++) begin
            exp_cyc += in_dly[i] + out_dly[i];
            exp_out += out_dly[i];
        end
        cyc = 0; done_cyc = -1; done_cnt = 0; post = 0;
        in_page = 0; in_wait = 0; out_page = 0; out_wait = 0; wr_idx = 0;
        n_col = 0; n_shr = 0; n_xor = 0; n_wr = 0; n_out = 0; last_wr_adr = 1'b0;

        @(negedge clk);
        total++;
        if (v_ready !== 1'b1) begin
            bad++;
            $display("FAIL %s ready_before_start got=%b exp=1", name, v_ready);
        end
        d_start  = 1'b1;
        d_bypass = byp;

        while (post < 3 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            d_start  = 1'b0;
            d_bypass = 1'($urandom_range(0, 1));
            if (v_col_shr) n_col++;
            if (v_reg_shr) n_shr++;
            if (v_xor_src) n_xor++;

            if (v_mem_wr) begin
                n_wr++;
                total++;
                if (v_adr_src) begin
                    last_wr_adr = 1'b1;
                    if (v_page !== 32'd0 || wr_idx != p) begin
                        bad++;
                        $display("FAIL %s wrapup_write page got=%0d exp=0 after %0d/%0d writes",
                                 name, v_page, wr_idx, p);
                    end
                end else begin
                    last_wr_adr = 1'b0;
                    if (v_page !== 32'(wr_idx)) begin
                        bad++;
                        $display("FAIL %s write_page got=%0d exp=%0d", name, v_page, wr_idx);
                    end
                    wr_idx++;
                end
            end
            if (v_mem_rd && v_adr_src) begin
                total++;
                if (v_page !== 32'd0) begin
                    bad++;
                    $display("FAIL %s ldf_page got=%0d exp=0", name, v_page);
                end
            end

            if (v_in_ready) begin
                total++;
                if (in_page >= p) begin
                    bad++;
                    $display("FAIL %s extra_in_ready got=%0d requests exp=%0d", name, in_page + 1, p);
                    d_in_valid = 1'b1;
                end else begin
                    if (v_page !== 32'(in_page)) begin
                        bad++;
                        $display("FAIL %s req_page got=%0d exp=%0d", name, v_page, in_page);
                    end
                    if (in_wait < in_dly[in_page]) begin
                        d_in_valid = 1'b0;
                        in_wait++;
                    end else begin
                        d_in_valid = 1'b1;
                        in_page++;
                        in_wait = 0;
                    end
                end
            end else begin
                d_in_valid = 1'($urandom_range(0, 1));
            end

            if (v_out_valid) begin
                n_out++;
                total++;
                if (out_page >= p) begin
                    bad++;
                    $display("FAIL %s extra_out_valid got=%0d pages exp=%0d", name, out_page + 1, p);
                    d_out_ready = 1'b1;
                end else begin
                    if (v_page !== 32'(out_page)) begin
                        bad++;
                        $display("FAIL %s out_page got=%0d exp=%0d", name, v_page, out_page);
                    end
                    if (poke && out_page == 1) d_start = 1'b1;
                    if (out_wait < out_dly[out_page]) begin
                        d_out_ready = 1'b0;
                        out_wait++;
                    end else begin
                        d_out_ready = 1'b1;
                        out_page++;
                        out_wait = 0;
                    end
                end
            end else begin
                d_out_ready = 1'($urandom_range(0, 1));
            end

            if (v_done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end else if (done_cyc >= 0) begin
                post++;
                total++;
                if (v_ready !== 1'b1) begin
                    bad++;
                    $display("FAIL %s ready_after_done got=%b exp=1", name, v_ready);
                end
            end
        end
        d_start = 1'b0; d_in_valid = 1'b0; d_out_ready = 1'b0; d_bypass = 1'b0;

        total++;
        if (done_cyc != exp_cyc) begin
            bad++;
            $display("FAIL %s done_cycle got=%0d exp=%0d (-1 = timeout)", name, done_cyc, exp_cyc);
        end
        total++;
        if (done_cnt != 1) begin
            bad++;
            $display("FAIL %s done_pulses got=%0d exp=1", name, done_cnt);
        end
        total++;
        if (in_page != p || out_page != p) begin
            bad++;
            $display("FAIL %s handshakes got in=%0d out=%0d exp=%0d", name, in_page, out_page, p);
        end
        total++;
        if (n_out != exp_out) begin
            bad++;
            $display("FAIL %s out_valid_cycles got=%0d exp=%0d", name, n_out, exp_out);
        end
        total++;
        if (n_wr != (byp ? p : p + 1) || last_wr_adr != !byp) begin
            bad++;
            $display("FAIL %s mem_wr got=%0d last_adr=%b exp=%0d last_adr=%b",
                     name, n_wr, last_wr_adr, byp ? p : p + 1, !byp);
        end
        total++;
        if (n_col != (byp ? 0 : (p + 1) * ROWS) || n_shr != (byp ? 0 : (p + 1) * ROWS * COLS)
            || n_xor != (byp ? 0 : ROWS * COLS)) begin
            bad++;
            $display("FAIL %s shift_counts got col=%0d shr=%0d xor=%0d exp col=%0d shr=%0d xor=%0d",
                     name, n_col, n_shr, n_xor, byp ? 0 : (p + 1) * ROWS,
                     byp ? 0 : (p + 1) * ROWS * COLS, byp ? 0 : ROWS * COLS);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        total++;
        if (v_ready !== 1'b1 || v_str !== 15'd0 || v_page !== 32'd0) begin
            bad++;
            $display("FAIL %s got ready=%b strobes=%h page=%0d exp ready=1 strobes=0 page=0",
                     name, v_ready, v_str, v_page);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset_idle");
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("after_release");
    endtask

    task automatic test_reset_mid_xor();
        int guard;
        bit seen_wr;
        guard = 0;
        seen_wr = 1'b0;
        @(negedge clk);
        d_start = 1'b1; d_in_valid = 1'b1; d_out_ready = 1'b1;
        @(negedge clk);
        d_start = 1'b0;
        while (!(seen_wr && v_reg_shr) && guard < 300) begin
            if (v_mem_wr) seen_wr = 1'b1;
            @(negedge clk);
            guard++;
        end
        total++;
        if (!(seen_wr && v_reg_shr)) begin
            bad++;
            $display("FAIL reset_mid_xor reached_xor got=0 exp=1");
        end
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("reset_async");
        @(posedge clk);
        #1 check_reset_outputs("reset_held");
        d_in_valid = 1'b0; d_out_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("reset_recovered");
    endtask

    task automatic test_nominal();
        clear_dly();
        run_block("nominal", 1'b0, 1'b0);
    endtask

    task automatic test_input_stall();
        clear_dly();
        in_dly[2] = 10;
        run_block("input_stall", 1'b0, 1'b0);
    endtask

    task automatic test_backpressure();
        clear_dly();
        for (int i = 0; i < 4; i++) out_dly[i] = 1;
        run_block("backpressure", 1'b0, 1'b0);
    endtask

    task automatic test_bypass();
        clear_dly();
        run_block("bypass", 1'b1, 1'b0);
    endtask

    task automatic test_random();
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 4; i++) begin
                in_dly[i]  = int'($urandom_range(0, 4));
                out_dly[i] = int'($urandom_range(0, 4));
            end
            run_block("random", 1'($urandom_range(0, 1)), 1'b0);
        end
    endtask

    task automatic test_boundary_pages3();
        sel3 = 1'b1;
        clear_dly();
        run_block("pages3_poke_start", 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            in_dly[i]  = int'($urandom_range(0, 3));
            out_dly[i] = int'($urandom_range(0, 3));
        end
        run_block("pages3_random", 1'b0, 1'b1);
        run_block("pages3_bypass", 1'b1, 1'b0);
        sel3 = 1'b0;
    endtask

    initial begin
        sel3 = 1'b0;
        d_start = 1'b0; d_bypass = 1'b0; d_in_valid = 1'b0; d_out_ready = 1'b0;
        clear_dly();
        test_reset();
        test_reset_mid_xor();
        test_nominal();
        test_input_stall();
        test_backpressure();
        test_bypass();
        test_random();
        test_boundary_pages3();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
